// File: rtl/vec_pack.sv
// Packs padded one-vector-per-group sub-vector words back into a dense bus stream.
// Padding bits in each vector's last word are dropped; a batch ends with a flagged flush.
module vec_pack #(
   parameter int BUS_WIDTH    = 128,
   parameter int VECTOR_WIDTH = 920,
   parameter int SUB_VEC_NO   = (VECTOR_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH,
   parameter bit REVERSE_OUT  = 1'b1
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [BUS_WIDTH-1:0] up_Vector,
   input  logic                 up_Valid,
   input  logic                 up_Last,
   output logic                 up_Ready,
   output logic [BUS_WIDTH-1:0] dn_Vector,
   output logic                 dn_Valid,
   output logic                 dn_Last,
   input  logic                 dn_Ready
);

   localparam int DELTA = SUB_VEC_NO * BUS_WIDTH - VECTOR_WIDTH;
   localparam int AW    = 2 * BUS_WIDTH;
   localparam int FW    = $clog2(AW) + 1;
   localparam int CW    = (SUB_VEC_NO > 1) ? $clog2(SUB_VEC_NO) : 1;

   localparam logic [FW-1:0] BW_F    = FW'(BUS_WIDTH);
   localparam logic [FW-1:0] LW_F    = FW'(BUS_WIDTH - DELTA);
   localparam logic [CW-1:0] CNT_MAX = CW'(SUB_VEC_NO - 1);
   localparam logic [BUS_WIDTH-1:0] LAST_MASK = {BUS_WIDTH{1'b1}} << DELTA;

   typedef enum logic {PACK, FLUSH} state_t;

   state_t               r_State, w_State_Nxt;
   logic [AW-1:0]        r_Acc, w_Acc_Sh, w_Acc_Nxt;
   logic [FW-1:0]        r_Fill, w_Fill_Sh, w_Fill_Nxt;
   logic [CW-1:0]        r_Cnt, w_Cnt_Nxt;
   logic                 w_Emit, w_Take, w_Last_Sub, w_Out_Free, w_Done;
   logic [BUS_WIDTH-1:0] w_Word, w_Top, w_Out;

   always_comb begin
      w_Out_Free = !dn_Valid || dn_Ready;
      // While flushing, any leftover bits are emitted as a final zero-padded word
      if (r_State == PACK)
         w_Emit = w_Out_Free && (r_Fill >= BW_F);
      else
         w_Emit = w_Out_Free && (r_Fill != '0);
      up_Ready   = rstn && (r_State == PACK) && ((r_Fill < BW_F) || w_Emit);
      w_Take     = up_Valid && up_Ready;
      w_Last_Sub = (r_Cnt == CNT_MAX);
      w_Word     = w_Last_Sub ? (up_Vector & LAST_MASK) : up_Vector;
      w_Done     = dn_Valid && dn_Ready && dn_Last;
      w_Top      = r_Acc[AW-1 -: BUS_WIDTH];

      w_Acc_Sh  = r_Acc;
      w_Fill_Sh = r_Fill;
      if (w_Emit) begin
         w_Acc_Sh  = r_Acc << BUS_WIDTH;
         w_Fill_Sh = (r_Fill >= BW_F) ? (r_Fill - BW_F) : '0;
      end

      w_Acc_Nxt  = w_Acc_Sh;
      w_Fill_Nxt = w_Fill_Sh;
      w_Cnt_Nxt  = r_Cnt;
      if (w_Take) begin
         w_Acc_Nxt  = w_Acc_Sh | ({w_Word, {BUS_WIDTH{1'b0}}} >> w_Fill_Sh);
         w_Fill_Nxt = w_Fill_Sh + (w_Last_Sub ? LW_F : BW_F);
         w_Cnt_Nxt  = w_Last_Sub ? '0 : r_Cnt + 1'b1;
      end

      w_State_Nxt = r_State;
      unique case (r_State)
         PACK:
            if (w_Take && up_Last) w_State_Nxt = FLUSH;
         FLUSH:
            if (w_Done) begin
               w_State_Nxt = PACK;
               w_Cnt_Nxt   = '0;
            end
         default: w_State_Nxt = PACK;
      endcase
   end

   if (REVERSE_OUT) begin : g_rev
      always_comb begin
         w_Out = '0;
         for (int j = 0; j < BUS_WIDTH; j++)
            w_Out[j] = w_Top[BUS_WIDTH-1-j];
      end
   end else begin : g_fwd
      assign w_Out = w_Top;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_State   <= PACK;
         r_Acc     <= '0;
         r_Fill    <= '0;
         r_Cnt     <= '0;
         dn_Vector <= '0;
         dn_Valid  <= 1'b0;
         dn_Last   <= 1'b0;
      end else begin
         r_State <= w_State_Nxt;
         r_Acc   <= w_Acc_Nxt;
         r_Fill  <= w_Fill_Nxt;
         r_Cnt   <= w_Cnt_Nxt;
         if (w_Emit) begin
            dn_Vector <= w_Out;
            dn_Valid  <= 1'b1;
            dn_Last   <= (r_State == FLUSH) && (r_Fill <= BW_F);
         end else if (dn_Valid && dn_Ready) begin
            dn_Valid <= 1'b0;
            dn_Last  <= 1'b0;
         end
      end
   end

endmodule
